cbus_arbiter: RTL and testbench
===============================

CBUS_ARBITER -- requirements
Module: cbus_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of cache-bus requesters (legal range 2..4).
REQ-002 The block SHALL have port clk  input  1  the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port ireqs  input  NUM_REQ x cbus_req_t  burst requests from the caches; index 0 is the instruction cache, index 1 the data cache.
REQ-005 The block SHALL have port oresps  output  NUM_REQ x cbus_resp_t  per-requester responses.
REQ-006 The block SHALL have port oreq  output  cbus_req_t  the single request driven to the memory-side cache bus.
REQ-007 The block SHALL have port iresp  input  cbus_resp_t  the response from the memory-side cache bus.

Function
REQ-008 The block SHALL implement two states: IDLE (no grant held) and BUSY (one requester granted); there is no other state.
REQ-009 In IDLE, oreq SHALL be all zeros and every oresps[i] SHALL be all zeros.
REQ-010 In IDLE, if any ireqs[i].valid is 1, the block SHALL pick one requester by round-robin, register its index as grant, and enter BUSY on the next edge.
REQ-011 Round-robin SHALL search upward from (last_grant+1) mod NUM_REQ and wrap around, so that the most recently served requester has lowest priority.
REQ-012 In IDLE with no valid request, the state and last_grant SHALL be unchanged.
REQ-013 In BUSY, oreq SHALL equal ireqs[grant] combinationally, with every field passed through unmodified (valid, is_write, size, addr, strobe, data, len, burst).
REQ-014 In BUSY, oresps[grant] SHALL equal iresp combinationally, and oresps[j] for j != grant SHALL be all zeros.
REQ-015 In BUSY, the grant SHALL be held, regardless of other requesters' valid, until a cycle with iresp.ready=1 and iresp.last=1; on that edge the block SHALL return to IDLE and set last_grant=grant.
REQ-016 A requester SHALL hold valid and all request fields stable from its first valid cycle until it sees ready&&last; the arbiter does not check this.
REQ-017 If ireqs[grant].valid falls to 0 in BUSY, the block SHALL still hold the grant and pass valid=0 on oreq; it SHALL release only on ready&&last.
REQ-018 iresp.ready without iresp.last in BUSY SHALL be forwarded to the granted requester and SHALL NOT change state.
REQ-019 iresp.ready or iresp.last in IDLE SHALL be ignored: nothing is forwarded and the state is unchanged.
REQ-020 Latency: a request that is valid in an IDLE cycle t and selected SHALL appear on oreq.valid in cycle t+1.
REQ-021 After release at the edge ending cycle t, the block SHALL spend cycle t+1 in IDLE, and the next grant's oreq.valid SHALL appear no earlier than cycle t+2.
REQ-022 A requester whose valid rises in the same cycle as another's ready&&last SHALL be considered in the following IDLE cycle.
REQ-023 Write transactions (is_write=1) SHALL be arbitrated identically to reads; the end of burst is still signalled by iresp.ready&&iresp.last.

Reset
REQ-024 When reset=1 at a rising edge, the block SHALL enter IDLE and set last_grant=NUM_REQ-1, so that requester 0 has highest priority after reset.
REQ-025 When reset=1, grant SHALL become 0, and all outputs SHALL be zero from the cycle after the reset edge.
REQ-026 Reset asserted during a BUSY burst SHALL abort the grant immediately, with no wait for last; any partial burst is discarded.
REQ-027 The block SHALL hold no other state.

Verification
REQ-028 Single read: ireqs[1] = valid, addr 0x8000_0040, len MLEN16; iresp gives 16 ready beats with last on beat 16 -> oreq.addr = 0x8000_0040 one cycle after request; oresps[1] carries 16 ready beats; oresps[0] stays zero; state is IDLE after beat 16.
REQ-029 Contention after reset: ireqs[0] and ireqs[1] both valid in the same cycle -> requester 0 is granted first; after its last beat, one IDLE cycle, then requester 1 is granted.
REQ-030 Fairness: both requesters continuously valid, 4 bursts of MLEN4 each -> grant order 0,1,0,1.
REQ-031 Hold: requester 1 raises valid during requester 0's burst with ready on beats 1-3 and last on beat 4 -> grant does not change before beat 4 is accepted.
REQ-032 Reset mid-burst: reset asserted after 3 of 8 beats -> the next cycle is IDLE with all outputs zero; a following ireqs[1] request is still preceded by requester 0 if both are valid.
REQ-033 Stray response: iresp.ready=1 and iresp.last=1 in IDLE -> no oresps activity and no state change.

Source files
------------

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter that lets several cache requesters share one memory-side cache bus.
// A grant is held for a whole burst and released only on the response beat flagged ready && last.

package cbus_pkg;
    typedef enum logic [2:0] {
        MLEN1  = 3'd0,
        MLEN2  = 3'd1,
        MLEN4  = 3'd2,
        MLEN8  = 3'd3,
        MLEN16 = 3'd4
    } cbus_len_t;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [7:0]  strobe;
        logic [63:0] data;
        cbus_len_t   len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
endpackage

module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  cbus_req_t  [NUM_REQ-1:0] ireqs,
    output cbus_resp_t [NUM_REQ-1:0] oresps,
    output cbus_req_t                oreq,
    input  cbus_resp_t               iresp
);

    localparam int GW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_lastGrant;
    logic [GW-1:0]   w_grantNext;
    logic [GW-1:0]   w_lastGrantNext;
    logic [GW-1:0]   w_pick;
    logic [GW-1:0]   w_cand;
    logic            w_anyValid;

    // Walk downward so the candidate closest above the last grant is written last and wins.
    always_comb begin
        w_pick     = '0;
        w_cand     = '0;
        w_anyValid = 1'b0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_cand = GW'((int'(r_lastGrant) + i) % NUM_REQ);
            if (ireqs[w_cand].valid) begin
                w_pick     = w_cand;
                w_anyValid = 1'b1;
            end
        end
    end

    always_comb begin
        w_stateNext     = r_state;
        w_grantNext     = r_grant;
        w_lastGrantNext = r_lastGrant;
        unique case (r_state)
            IDLE: begin
                if (w_anyValid) begin
                    w_stateNext = BUSY;
                    w_grantNext = w_pick;
                end
            end
            BUSY: begin
                if (iresp.ready && iresp.last) begin
                    w_stateNext     = IDLE;
                    w_lastGrantNext = r_grant;
                end
            end
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant     <= '0;
            r_lastGrant <= GW'(NUM_REQ - 1);
        end else begin
            r_state     <= w_stateNext;
            r_grant     <= w_grantNext;
            r_lastGrant <= w_lastGrantNext;
        end
    end

    always_comb begin
        oreq   = '0;
        oresps = '0;
        if (r_state == BUSY) begin
            oreq            = ireqs[r_grant];
            oresps[r_grant] = iresp;
        end
    end

endmodule

// File: tb/tb_cbus_arbiter.sv
// Directed self-checking bench for cbus_arbiter: reset, stray responses, single burst,
// fairness, grant hold, dropped valid and reset in the middle of a burst.

module tb_cbus_arbiter;
    import cbus_pkg::*;

    localparam int NUM_REQ = 2;

    logic                     clk;
    logic                     reset;
    cbus_req_t  [NUM_REQ-1:0] ireqs;
    cbus_resp_t [NUM_REQ-1:0] oresps;
    cbus_req_t                oreq;
    cbus_resp_t               iresp;

    int checksTotal  = 0;
    int checksPassed = 0;

    cbus_req_t  reqA;
    cbus_req_t  reqB;
    cbus_req_t  reqC;
    cbus_req_t  reqOff;
    cbus_resp_t stray;

    cbus_arbiter #(.NUM_REQ(NUM_REQ)) dut (
        .clk    (clk),
        .reset  (reset),
        .ireqs  (ireqs),
        .oresps (oresps),
        .oreq   (oreq),
        .iresp  (iresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic cbus_req_t makeReq(input logic [31:0] addr, input cbus_len_t len,
                                          input logic isWrite, input logic [63:0] data);
        cbus_req_t r;
        r.valid    = 1'b1;
        r.is_write = isWrite;
        r.size     = 3'd3;
        r.addr     = addr;
        r.strobe   = 8'hFF;
        r.data     = data;
        r.len      = len;
        r.burst    = 2'b01;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checksTotal++;
        if (observed === expected)
            checksPassed++;
        else
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input cbus_req_t r0, input cbus_req_t r1, input cbus_resp_t resp);
        ireqs[0] = r0;
        ireqs[1] = r1;
        iresp    = resp;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " oreq"}, 128'(oreq), '0);
        for (int j = 0; j < NUM_REQ; j++)
            checkOutput($sformatf("%s oresps[%0d]", tag, j), 128'(oresps[j]), '0);
    endtask

    task automatic checkBusy(input string tag, input int idx, input cbus_req_t expReq,
                             input cbus_resp_t expResp);
        checkOutput({tag, " oreq"}, 128'(oreq), 128'(expReq));
        for (int j = 0; j < NUM_REQ; j++) begin
            if (j == idx)
                checkOutput($sformatf("%s oresps[%0d]", tag, j), 128'(oresps[j]), 128'(expResp));
            else
                checkOutput($sformatf("%s oresps[%0d]", tag, j), 128'(oresps[j]), '0);
        end
    endtask

    // One response beat: drive it, check the routing, then advance past the edge.
    task automatic beat(input string tag, input int idx, input cbus_req_t expReq,
                        input logic isLast, input int n);
        cbus_resp_t resp;
        resp.ready = 1'b1;
        resp.last  = isLast;
        resp.data  = {32'(idx), 32'(n)};
        iresp      = resp;
        #1;
        checkBusy($sformatf("%s beat%0d", tag, n), idx, expReq, resp);
        tick();
    endtask

    task automatic runBurst(input string tag, input int idx, input cbus_req_t expReq,
                            input int nBeats);
        for (int b = 1; b <= nBeats; b++)
            beat(tag, idx, expReq, b == nBeats, b);
        iresp = '0;
    endtask

    task automatic resetDut();
        reset = 1'b1;
        applyStimulus('0, '0, '0);
        tick();
        reset = 1'b0;
        #1;
        checkIdle("reset");
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus('0, '0, '0);
        resetDut();

        // Stray ready/last while idle must be ignored.
        stray = '{ready: 1'b1, last: 1'b1, data: 64'hDEAD_BEEF_0000_0001};
        applyStimulus('0, '0, stray);
        #1;
        checkIdle("stray");
        tick();
        applyStimulus('0, '0, '0);
        #1;
        checkIdle("stray after");

        // Single 16-beat read from the data cache.
        reqB = makeReq(32'h8000_0040, MLEN16, 1'b0, 64'h0);
        applyStimulus('0, reqB, '0);
        #1;
        checkIdle("read req cycle");
        tick();
        #1;
        checkOutput("read addr", 128'(oreq.addr), 128'(32'h8000_0040));
        runBurst("read", 1, reqB, 16);
        applyStimulus('0, '0, '0);
        #1;
        checkIdle("read done");

        // Contention after reset and fairness: grant order 0,1,0,1 with an idle gap each time.
        resetDut();
        reqA = makeReq(32'h0000_1000, MLEN4, 1'b0, 64'h0);
        reqB = makeReq(32'h0000_2000, MLEN4, 1'b1, 64'h1234_5678_9ABC_DEF0);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(reqA, reqB, '0);
            #1;
            checkIdle($sformatf("fair%0d gap", k));
            tick();
            runBurst($sformatf("fair%0d", k), k % 2, (k % 2 == 1) ? reqB : reqA, 4);
        end

        // Requester 1 arrives mid-burst; the grant stays with requester 0 until last.
        resetDut();
        reqA = makeReq(32'h0000_3000, MLEN4, 1'b1, 64'hAAAA_5555_AAAA_5555);
        applyStimulus(reqA, '0, '0);
        tick();
        beat("hold", 0, reqA, 1'b0, 1);
        ireqs[1] = reqB;
        runBurst("hold", 0, reqA, 3);
        applyStimulus('0, reqB, '0);
        #1;
        checkIdle("hold gap");
        tick();
        #1;
        checkOutput("hold next grant", 128'(oreq), 128'(reqB));

        // Granted requester drops valid: grant persists and valid=0 is passed through.
        reqOff       = reqB;
        reqOff.valid = 1'b0;
        ireqs[1]     = reqOff;
        runBurst("dropvalid", 1, reqOff, 2);
        applyStimulus('0, '0, '0);
        #1;
        checkIdle("dropvalid done");

        // Reset after 3 of 8 beats aborts the burst; requester 0 then wins again.
        resetDut();
        reqC = makeReq(32'h0000_4000, MLEN8, 1'b0, 64'h0);
        applyStimulus('0, reqC, '0);
        tick();
        for (int b = 1; b <= 3; b++)
            beat("abort", 1, reqC, 1'b0, b);
        reset = 1'b1;
        applyStimulus(reqA, reqC, '0);
        tick();
        reset = 1'b0;
        #1;
        checkIdle("post reset");
        tick();
        #1;
        checkOutput("post reset grant", 128'(oreq), 128'(reqA));

        resetDut();
        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
